// File: rtl/ser_sched_pkg.sv
// Shared types and helpers for the serializer round-robin scheduler.
package ser_sched_pkg;

    typedef enum logic [1:0] {
        IDLE       = 2'd0,
        WAIT_START = 2'd1,
        WAIT_DONE  = 2'd2
    } state_e;

    // Smallest non-zero mod the serializer can transmit; 0 encodes a full word.
    localparam int MIN_MOD = 3;

    function automatic logic mod_is_valid(input int unsigned mod);
        return (mod == 0) || (mod >= MIN_MOD);
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter: the first requester after ptr wins,
// wrapping modulo N. Produces a one-hot grant plus its encoded index.
module rr_arbiter #(
    parameter int N  = 4,
    parameter int IW = $clog2(N)
) (
    input  logic [N-1:0]  req,
    input  logic [IW-1:0] ptr,
    output logic [N-1:0]  gnt,
    output logic [IW-1:0] idx,
    output logic          any
);

    // Scan ptr+1 .. ptr+N (wrapped) and keep the first active request.
    always_comb begin
        int unsigned pos;
        gnt = '0;
        idx = '0;
        any = 1'b0;
        pos = 0;
        for (int i = 1; i <= N; i++) begin
            pos = 32'(ptr) + 32'(i);
            if (pos >= 32'(N)) pos = pos - 32'(N);
            if (!any && req[IW'(pos)]) begin
                any              = 1'b1;
                gnt[IW'(pos)]    = 1'b1;
                idx              = IW'(pos);
            end
        end
    end

endmodule

// File: rtl/ser_rr_scheduler.sv
// ser_rr_scheduler: time-shares one serializer among CH_NUM word producers.
// One word in flight at a time; words with an untransmittable mod are dropped.
// Optional per-channel issue/drop statistics: define SER_RR_SCHEDULER_STAT_EN.
module ser_rr_scheduler
    import ser_sched_pkg::*;
#(
    parameter int  CH_NUM     = 4,
    parameter int  DATA_W     = 16,
    parameter int  DATA_MOD_W = 4,
    parameter int  START_TMO  = 4,
    localparam int ID_W       = $clog2(CH_NUM)
) (
    input  logic                               clk_i,
    input  logic                               srst_n_i,
    input  logic [CH_NUM-1:0][DATA_W-1:0]      req_data_i,
    input  logic [CH_NUM-1:0][DATA_MOD_W-1:0]  req_mod_i,
    input  logic [CH_NUM-1:0]                  req_val_i,
    output logic [CH_NUM-1:0]                  req_ready_o,
    output logic [DATA_W-1:0]                  ser_data_o,
    output logic [DATA_MOD_W-1:0]              ser_data_mod_o,
    output logic                               ser_data_val_o,
    input  logic                               ser_busy_i,
    output logic [ID_W-1:0]                    grant_id_o,
    output logic                               drop_o,
`ifdef SER_RR_SCHEDULER_STAT_EN
    output logic                               tmo_o,
    output logic [CH_NUM-1:0][15:0]            stat_issued_o,
    output logic [CH_NUM-1:0][15:0]            stat_dropped_o
`else
    output logic                               tmo_o
`endif
);

    localparam int CNT_W = $clog2(START_TMO + 1);

    state_e                 state_q, state_d;
    logic [ID_W-1:0]        ptr_q;
    logic [CNT_W-1:0]       cnt_q;

    logic [CH_NUM-1:0]      arb_gnt;
    logic [ID_W-1:0]        arb_idx;
    logic                   arb_any;

    logic                   can_grant;
    logic                   accept;
    logic                   mod_ok;
    logic                   issue;
    logic                   drop;
    logic                   tmo;
    logic                   cnt_last;
    logic [DATA_MOD_W-1:0]  sel_mod;

    rr_arbiter #(
        .N  (CH_NUM),
        .IW (ID_W)
    ) u_arb (
        .req (req_val_i),
        .ptr (ptr_q),
        .gnt (arb_gnt),
        .idx (arb_idx),
        .any (arb_any)
    );

    assign sel_mod  = req_mod_i[arb_idx];
    assign cnt_last = (cnt_q == CNT_W'(START_TMO - 1));

    // State register.
    always_ff @(posedge clk_i) begin
        if (!srst_n_i) state_q <= IDLE;
        else           state_q <= state_d;
    end

    // Next state: issue opens the busy handshake, busy rise/fall closes it.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:       if (issue) state_d = WAIT_START;
            WAIT_START: begin
                if (ser_busy_i)    state_d = WAIT_DONE;
                else if (cnt_last) state_d = IDLE;
            end
            WAIT_DONE:  if (!ser_busy_i) state_d = IDLE;
            default:    state_d = IDLE;
        endcase
    end

    // Ready gating and the per-cycle issue/drop/timeout decisions.
    always_comb begin
        can_grant   = srst_n_i && (state_q == IDLE) && !ser_busy_i;
        req_ready_o = can_grant ? arb_gnt : '0;
        accept      = can_grant && arb_any;
        mod_ok      = mod_is_valid(32'(sel_mod));
        issue       = accept && mod_ok;
        drop        = accept && !mod_ok;
        tmo         = (state_q == WAIT_START) && !ser_busy_i && cnt_last;
    end

    // Start-wait counter: zero outside WAIT_START so every entry starts fresh.
    always_ff @(posedge clk_i) begin
        if (!srst_n_i || state_q != WAIT_START) cnt_q <= '0;
        else                                    cnt_q <= cnt_q + CNT_W'(1);
    end

    // Registered serializer interface, pulses, and round-robin pointer.
    always_ff @(posedge clk_i) begin
        if (!srst_n_i) begin
            ptr_q          <= ID_W'(CH_NUM - 1);
            grant_id_o     <= '0;
            ser_data_o     <= '0;
            ser_data_mod_o <= '0;
            ser_data_val_o <= 1'b0;
            drop_o         <= 1'b0;
            tmo_o          <= 1'b0;
        end else begin
            ser_data_val_o <= issue;
            drop_o         <= drop;
            tmo_o          <= tmo;
            if (accept) begin
                ptr_q      <= arb_idx;
                grant_id_o <= arb_idx;
            end
            if (issue) begin
                ser_data_o     <= req_data_i[arb_idx];
                ser_data_mod_o <= sel_mod;
            end
        end
    end

`ifdef SER_RR_SCHEDULER_STAT_EN
    // Saturating per-channel counters, updated on the edge that raises the pulse.
    always_ff @(posedge clk_i) begin
        if (!srst_n_i) begin
            stat_issued_o  <= '0;
            stat_dropped_o <= '0;
        end else begin
            for (int ch = 0; ch < CH_NUM; ch++) begin
                if (arb_idx == ID_W'(ch)) begin
                    if (issue && stat_issued_o[ch] != 16'hFFFF)
                        stat_issued_o[ch] <= stat_issued_o[ch] + 16'd1;
                    if (drop && stat_dropped_o[ch] != 16'hFFFF)
                        stat_dropped_o[ch] <= stat_dropped_o[ch] + 16'd1;
                end
            end
        end
    end
`endif

endmodule

// File: tb/tb_ser_rr_scheduler.sv
// Directed bench for ser_rr_scheduler with an issue/drop scoreboard.
module tb_ser_rr_scheduler;

    localparam int CH  = 4;
    localparam int DW  = 16;
    localparam int MW  = 4;

    typedef struct {
        int              ch;
        logic [DW-1:0]   d;
        logic [MW-1:0]   m;
    } exp_t;

    logic                    clk_i = 1'b0;
    logic                    srst_n_i;
    logic [CH-1:0][DW-1:0]   req_data_i;
    logic [CH-1:0][MW-1:0]   req_mod_i;
    logic [CH-1:0]           req_val_i;
    logic [CH-1:0]           req_ready_o;
    logic [DW-1:0]           ser_data_o;
    logic [MW-1:0]           ser_data_mod_o;
    logic                    ser_data_val_o;
    logic                    ser_busy_i;
    logic [1:0]              grant_id_o;
    logic                    drop_o;
    logic                    tmo_o;
`ifdef SER_RR_SCHEDULER_STAT_EN
    logic [CH-1:0][15:0]     stat_issued_o;
    logic [CH-1:0][15:0]     stat_dropped_o;
    int                      iss_n [CH];
    int                      drp_n [CH];
`endif

    exp_t exp_q [$];
    int   drop_q [$];
    int   passed = 0;
    int   total  = 0;

    always #5 clk_i = ~clk_i;

    ser_rr_scheduler #(
        .CH_NUM     (CH),
        .DATA_W     (DW),
        .DATA_MOD_W (MW),
        .START_TMO  (4)
    ) dut (
        .clk_i          (clk_i),
        .srst_n_i       (srst_n_i),
        .req_data_i     (req_data_i),
        .req_mod_i      (req_mod_i),
        .req_val_i      (req_val_i),
        .req_ready_o    (req_ready_o),
        .ser_data_o     (ser_data_o),
        .ser_data_mod_o (ser_data_mod_o),
        .ser_data_val_o (ser_data_val_o),
        .ser_busy_i     (ser_busy_i),
        .grant_id_o     (grant_id_o),
        .drop_o         (drop_o),
`ifdef SER_RR_SCHEDULER_STAT_EN
        .tmo_o          (tmo_o),
        .stat_issued_o  (stat_issued_o),
        .stat_dropped_o (stat_dropped_o)
`else
        .tmo_o          (tmo_o)
`endif
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: got %0h want %0h", tag, obs, exp);
    endtask

    // Scoreboard pop: every issue/drop pulse must match the oldest expectation.
    task automatic mon();
        exp_t e;
        int   c;
        if (ser_data_val_o === 1'b1) begin
            if (exp_q.size() == 0) chk("unexpected_issue", 32'(ser_data_val_o), 32'(0));
            else begin
                e = exp_q.pop_front();
                chk("issue_data", 32'(ser_data_o), 32'(e.d));
                chk("issue_mod", 32'(ser_data_mod_o), 32'(e.m));
                chk("issue_id", 32'(grant_id_o), 32'(e.ch));
            end
        end
        if (drop_o === 1'b1) begin
            if (drop_q.size() == 0) chk("unexpected_drop", 32'(drop_o), 32'(0));
            else begin
                c = drop_q.pop_front();
                chk("drop_id", 32'(grant_id_o), 32'(c));
            end
        end
    endtask

    task automatic cyc();
        @(negedge clk_i);
        mon();
    endtask

    // Push what a granted word from channel ch must turn into.
    task automatic expect_word(input int ch);
        exp_t e;
        e.ch = ch;
        e.d  = req_data_i[ch];
        e.m  = req_mod_i[ch];
        if (e.m == 0 || e.m >= 3) begin
            exp_q.push_back(e);
`ifdef SER_RR_SCHEDULER_STAT_EN
            iss_n[ch]++;
`endif
        end else begin
            drop_q.push_back(ch);
`ifdef SER_RR_SCHEDULER_STAT_EN
            drp_n[ch]++;
`endif
        end
    endtask

    task automatic clr_stats();
`ifdef SER_RR_SCHEDULER_STAT_EN
        for (int c = 0; c < CH; c++) begin
            iss_n[c] = 0;
            drp_n[c] = 0;
        end
`endif
    endtask

    // Wait (bounded) for any ready, then require it to be channel ch.
    task automatic wait_grant(input int ch, input string tag);
        int k;
        k = 0;
        #1;
        while (req_ready_o == '0 && k < 40) begin
            cyc();
            #1;
            k++;
        end
        chk(tag, 32'(req_ready_o), 32'(1) << ch);
        if (req_ready_o != '0) expect_word(ch);
    endtask

    // Serializer busy for n cycles starting in the issue cycle; ends in IDLE.
    task automatic serve(input int n);
        ser_busy_i = 1'b1;
        for (int i = 0; i < n; i++) begin
            cyc();
            #1;
            chk("busy_no_ready", 32'(req_ready_o), 32'(0));
        end
        ser_busy_i = 1'b0;
        cyc();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1);
    end

    initial begin
        srst_n_i   = 1'b0;
        req_data_i = '0;
        req_mod_i  = '0;
        req_val_i  = '0;
        ser_busy_i = 1'b0;
        clr_stats();
        repeat (3) cyc();
        #1;
        chk("rst_ready", 32'(req_ready_o), 32'(0));
        chk("rst_val", 32'(ser_data_val_o), 32'(0));
        chk("rst_drop", 32'(drop_o), 32'(0));
        chk("rst_tmo", 32'(tmo_o), 32'(0));
        chk("rst_gid", 32'(grant_id_o), 32'(0));
        chk("rst_data", 32'(ser_data_o), 32'(0));
        srst_n_i = 1'b1;

        // Single word on ch2, long busy, then re-grant right after busy falls.
        cyc();
        req_data_i[2] = 16'hA5C3;
        req_mod_i[2]  = 4'd0;
        req_val_i     = 4'b0100;
        #1;
        chk("t1_ready", 32'(req_ready_o), 32'(4'b0100));
        expect_word(2);
        cyc();
        req_val_i = '0;
        #1;
        chk("t1_val", 32'(ser_data_val_o), 32'(1));
        ser_busy_i    = 1'b1;
        req_data_i[1] = 16'h1111;
        req_mod_i[1]  = 4'd5;
        req_val_i[1]  = 1'b1;
        repeat (15) begin
            cyc();
            #1;
            chk("t1_busy_ready", 32'(req_ready_o), 32'(0));
        end
        chk("t1_single_pulse", 32'(ser_data_val_o), 32'(0));
        cyc();
        ser_busy_i = 1'b0;
        #1;
        chk("t1_hold", 32'(req_ready_o), 32'(0));
        cyc();
        #1;
        chk("t1_regrant", 32'(req_ready_o), 32'(4'b0010));
        expect_word(1);
        cyc();
        req_val_i = '0;
        serve(2);

        // Reset, then all channels valid: grant order 0,1,2,3,0.
        srst_n_i = 1'b0;
        cyc();
        srst_n_i = 1'b1;
        clr_stats();
        for (int c = 0; c < CH; c++) begin
            req_data_i[c] = 16'h1000 + 16'(c);
            req_mod_i[c]  = 4'd0;
        end
        req_val_i = 4'b1111;
        for (int g = 0; g < 5; g++) begin
            wait_grant(g % CH, "t2_rr_order");
            cyc();
            if (g == 4) req_val_i = '0;
            serve(3);
        end

        // Drop on ch1 (mod 2), ch3 granted the very next cycle.
        req_data_i[1] = 16'h2222;
        req_mod_i[1]  = 4'd2;
        req_data_i[3] = 16'h3333;
        req_mod_i[3]  = 4'd0;
        req_val_i     = 4'b1010;
        wait_grant(1, "t3_drop_grant");
        cyc();
        req_val_i[1] = 1'b0;
        #1;
        chk("t3_drop", 32'(drop_o), 32'(1));
        chk("t3_noval", 32'(ser_data_val_o), 32'(0));
        chk("t3_gid", 32'(grant_id_o), 32'(1));
        chk("t3_next", 32'(req_ready_o), 32'(4'b1000));
        expect_word(3);

        // Timeout: busy never rises after the ch3 issue.
        cyc();
        req_val_i = '0;
        #1;
        chk("t4_tmo_early", 32'(tmo_o), 32'(0));
        req_data_i[2] = 16'h4444;
        req_mod_i[2]  = 4'd4;
        req_val_i[2]  = 1'b1;
        repeat (3) begin
            cyc();
            #1;
            chk("t4_tmo_early", 32'(tmo_o), 32'(0));
            chk("t4_wait_ready", 32'(req_ready_o), 32'(0));
        end
        cyc();
        #1;
        chk("t4_tmo", 32'(tmo_o), 32'(1));
        chk("t4_idle_ready", 32'(req_ready_o), 32'(4'b0100));
        expect_word(2);
        cyc();
        req_val_i = '0;
        #1;
        chk("t4_tmo_pulse", 32'(tmo_o), 32'(0));
        serve(2);

        // Reset during WAIT_DONE; afterwards ch0 beats ch3.
        req_data_i[1] = 16'h5555;
        req_mod_i[1]  = 4'd0;
        req_val_i     = 4'b0010;
        wait_grant(1, "t5_pre_grant");
        cyc();
        req_val_i  = '0;
        ser_busy_i = 1'b1;
        cyc();
        cyc();
        srst_n_i      = 1'b0;
        req_data_i[0] = 16'h0A0A;
        req_mod_i[0]  = 4'd0;
        req_data_i[3] = 16'h0B0B;
        req_mod_i[3]  = 4'd0;
        req_val_i     = 4'b1001;
        #1;
        chk("t5_busy_ready", 32'(req_ready_o), 32'(0));
        cyc();
        ser_busy_i = 1'b0;
        clr_stats();
        #1;
        chk("t5_rst_ready", 32'(req_ready_o), 32'(0));
        chk("t5_rst_val", 32'(ser_data_val_o), 32'(0));
        chk("t5_rst_drop", 32'(drop_o), 32'(0));
        chk("t5_rst_tmo", 32'(tmo_o), 32'(0));
        chk("t5_rst_gid", 32'(grant_id_o), 32'(0));
        chk("t5_rst_data", 32'(ser_data_o), 32'(0));
        chk("t5_rst_mod", 32'(ser_data_mod_o), 32'(0));
        srst_n_i = 1'b1;
        #1;
        chk("t5_ch0_first", 32'(req_ready_o), 32'(4'b0001));
        expect_word(0);
        cyc();
        req_val_i = '0;
        serve(2);

        // Externally busy serializer blocks all ready while IDLE.
        ser_busy_i    = 1'b1;
        req_data_i[2] = 16'h6666;
        req_mod_i[2]  = 4'd15;
        req_val_i     = 4'b0100;
        repeat (3) begin
            cyc();
            #1;
            chk("t6_ext_busy", 32'(req_ready_o), 32'(0));
        end
        ser_busy_i = 1'b0;
        #1;
        chk("t6_release", 32'(req_ready_o), 32'(4'b0100));
        expect_word(2);
        cyc();
        req_val_i = '0;
        serve(2);

        // Mod 1 is also untransmittable.
        req_data_i[1] = 16'h7777;
        req_mod_i[1]  = 4'd1;
        req_val_i     = 4'b0010;
        #1;
        chk("t7_ready", 32'(req_ready_o), 32'(4'b0010));
        expect_word(1);
        cyc();
        req_val_i = '0;
        #1;
        chk("t7_drop", 32'(drop_o), 32'(1));
        chk("t7_noval", 32'(ser_data_val_o), 32'(0));
        cyc();
        #1;
        chk("t7_drop_pulse", 32'(drop_o), 32'(0));

        chk("issue_q_drained", 32'(exp_q.size()), 32'(0));
        chk("drop_q_drained", 32'(drop_q.size()), 32'(0));
`ifdef SER_RR_SCHEDULER_STAT_EN
        for (int c = 0; c < CH; c++) begin
            chk("stat_issued", 32'(stat_issued_o[c]), 32'(iss_n[c]));
            chk("stat_dropped", 32'(stat_dropped_o[c]), 32'(drp_n[c]));
        end
`endif

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
